// File: rtl/mux16x1_pkg.sv
// Shared constants and the lane-index type for the 16:1 conditional-select mux.
package mux16x1_pkg;

   localparam int NUM_IN = 16;
   localparam int SEL_W  = 4;

   typedef logic [SEL_W-1:0] lane_idx_t;

endpackage

// File: rtl/mux16x1_mux2.sv
// DATA_W-wide 2:1 select, one node of the 16:1 selection tree.
module mux16x1_mux2 #(
   parameter int DATA_W = 1
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sel,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      if (sel) y = b;
      else     y = a;
   end

endmodule

// File: rtl/mux16x1_using_conditional_statement_design.sv
// 16:1 mux built as a 4-level tree of 2:1 conditional selects, with an optional
// registered output stage compiled in by defining MUX16X1_REG_OUT_EN.
module mux16x1_using_conditional_statement_design
   import mux16x1_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN*DATA_W-1:0] d,
   input  lane_idx_t                s,
   input  logic                     vld_in,
   output logic [DATA_W-1:0]        y,
   output logic [DATA_W-1:0]        y_q,
   output logic                     vld_q
);

   logic [8*DATA_W-1:0] lvl0;
   logic [4*DATA_W-1:0] lvl1;
   logic [2*DATA_W-1:0] lvl2;

   // Leaves pair adjacent lanes on s[0]; each higher level halves on the next select bit.
   for (genvar i = 0; i < 8; i++) begin : g_lvl0
      mux16x1_mux2 #(.DATA_W(DATA_W)) u_node (
         .a   (d[(2*i)*DATA_W +: DATA_W]),
         .b   (d[(2*i+1)*DATA_W +: DATA_W]),
         .sel (s[0]),
         .y   (lvl0[i*DATA_W +: DATA_W])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_lvl1
      mux16x1_mux2 #(.DATA_W(DATA_W)) u_node (
         .a   (lvl0[(2*i)*DATA_W +: DATA_W]),
         .b   (lvl0[(2*i+1)*DATA_W +: DATA_W]),
         .sel (s[1]),
         .y   (lvl1[i*DATA_W +: DATA_W])
      );
   end

   for (genvar i = 0; i < 2; i++) begin : g_lvl2
      mux16x1_mux2 #(.DATA_W(DATA_W)) u_node (
         .a   (lvl1[(2*i)*DATA_W +: DATA_W]),
         .b   (lvl1[(2*i+1)*DATA_W +: DATA_W]),
         .sel (s[2]),
         .y   (lvl2[i*DATA_W +: DATA_W])
      );
   end

   mux16x1_mux2 #(.DATA_W(DATA_W)) u_root (
      .a   (lvl2[0 +: DATA_W]),
      .b   (lvl2[DATA_W +: DATA_W]),
      .sel (s[3]),
      .y   (y)
   );

`ifdef MUX16X1_REG_OUT_EN
   // Reset wins over a capture; an idle cycle keeps the last sample but drops its valid flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= vld_in;
         if (vld_in) y_q <= y;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
   assign y_q            = y;
   assign vld_q          = vld_in;
`endif

endmodule

// File: tb/tb_mux16x1_using_conditional_statement_design.sv
// Scoreboard bench for the 16:1 mux at DATA_W=1 and DATA_W=8; follows MUX16X1_REG_OUT_EN.
module tb_mux16x1_using_conditional_statement_design;

   typedef struct {
      logic       yq1;
      logic [7:0] yq8;
      logic       vq;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         vld_in;
   logic [3:0]   s;
   logic [15:0]  d1;
   logic [127:0] d8;
   logic         y1, yq1, vq1;
   logic [7:0]   y8, yq8;
   logic         vq8;

   int   checks;
   int   errors;
   exp_t sb[$];

   logic       m_yq1;
   logic [7:0] m_yq8;
   logic       m_vq;

   mux16x1_using_conditional_statement_design #(.DATA_W(1)) dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (d1),
      .s      (s),
      .vld_in (vld_in),
      .y      (y1),
      .y_q    (yq1),
      .vld_q  (vq1)
   );

   mux16x1_using_conditional_statement_design #(.DATA_W(8)) dut8 (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (d8),
      .s      (s),
      .vld_in (vld_in),
      .y      (y8),
      .y_q    (yq8),
      .vld_q  (vq8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one cycle of stimulus, checks y at once and y_q/vld_q when the DUT presents them.
   task automatic applyStimulus(input string tag, input logic rst, input logic vld,
                                input logic [3:0] sel, input logic [15:0] dv1,
                                input logic [127:0] dv8);
      logic       e1;
      logic [7:0] e8;
      exp_t       it;
      @(negedge clk);
      rst_n  = rst;
      vld_in = vld;
      s      = sel;
      d1     = dv1;
      d8     = dv8;
      e1     = dv1[sel];
      e8     = 8'((dv8 >> (32'(sel) * 8)) & 128'hFF);
      #1;
      checkOutput({tag, ":y1"}, 32'(y1), 32'(e1));
      checkOutput({tag, ":y8"}, 32'(y8), 32'(e8));
`ifdef MUX16X1_REG_OUT_EN
      if (!rst) begin
         m_yq1 = 1'b0;
         m_yq8 = 8'h00;
         m_vq  = 1'b0;
      end else begin
         m_vq = vld;
         if (vld) begin
            m_yq1 = e1;
            m_yq8 = e8;
         end
      end
`else
      m_yq1 = e1;
      m_yq8 = e8;
      m_vq  = vld;
`endif
      sb.push_back('{yq1: m_yq1, yq8: m_yq8, vq: m_vq});
`ifdef MUX16X1_REG_OUT_EN
      @(posedge clk);
      #1;
`endif
      it = sb.pop_front();
      checkOutput({tag, ":yq1"}, 32'(yq1), 32'(it.yq1));
      checkOutput({tag, ":yq8"}, 32'(yq8), 32'(it.yq8));
      checkOutput({tag, ":vq1"}, 32'(vq1), 32'(it.vq));
      checkOutput({tag, ":vq8"}, 32'(vq8), 32'(it.vq));
   endtask

   logic [127:0] ramp8;
   logic [15:0]  sweep_y;

   initial begin
      checks = 0;
      errors = 0;
      m_yq1  = 1'b0;
      m_yq8  = 8'h00;
      m_vq   = 1'b0;
      rst_n  = 1'b0;
      vld_in = 1'b0;
      s      = 4'd0;
      d1     = 16'h0000;
      d8     = '0;
      for (int k = 0; k < 16; k++) ramp8[k*8 +: 8] = 8'h10 + 8'(k);
      sweep_y = 16'b1010_0101_1100_0011;

      applyStimulus("reset0", 1'b0, 1'b0, 4'd0, 16'h0000, '0);
      applyStimulus("reset1", 1'b0, 1'b1, 4'd5, 16'h0020, ramp8);

      for (int k = 0; k < 16; k++) begin
         applyStimulus($sformatf("sweep%0d", k), 1'b1, 1'b0, 4'(k), 16'hA5C3, ramp8);
         checkOutput($sformatf("sweep%0d:tbl", k), 32'(y1), 32'(sweep_y[k]));
      end

      applyStimulus("s15_w8", 1'b1, 1'b0, 4'd15, 16'hA5C3, ramp8);
      checkOutput("s15_w8:1F", 32'(y8), 32'h1F);
      applyStimulus("s0_w8", 1'b1, 1'b0, 4'd0, 16'hA5C3, ramp8);
      checkOutput("s0_w8:10", 32'(y8), 32'h10);

      applyStimulus("cap_s6", 1'b1, 1'b1, 4'd6, 16'hA5C3, ramp8);
      applyStimulus("hold_s6", 1'b1, 1'b0, 4'd6, 16'hA5C3, ramp8);
      applyStimulus("hold_s4", 1'b1, 1'b0, 4'd4, 16'h0000, ~ramp8);
      applyStimulus("hold_s9", 1'b1, 1'b0, 4'd9, 16'hFFFF, '0);

      applyStimulus("rst_pri", 1'b0, 1'b1, 4'd3, 16'hFFFF, ~128'h0);
      checkOutput("rst_pri:y1", 32'(y1), 32'h1);

      for (int k = 0; k < 16; k++)
         applyStimulus($sformatf("b2b%0d", k), 1'b1, 1'b1, 4'(k), 16'h8001, ramp8);

      for (int n = 0; n < 48; n++)
         applyStimulus($sformatf("rnd%0d", n), ($urandom_range(0, 9) != 0),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       16'($urandom), {$urandom, $urandom, $urandom, $urandom});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
